icache_refill_controller: RTL and testbench
===========================================

# icache_refill_controller

Sequences the refill of one 16-word instruction-cache line from next-level memory after a miss. It issues one wrapping burst request that returns the critical word first. It steers each returned beat into the line store through a 4-bit word index, which matches the cache's 16:1 word-select width. It forwards the critical word early, then commits the tag once the line is complete. It sits between the cache hit/miss logic and the memory interface, and holds the fetch stage stalled while busy.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, instruction word width; line fixed at 16 words (word offset = addr[5:2], line address = addr[ADDR_WIDTH-1:6])
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- MISS  in  1  miss request; sampled only in IDLE
- MISS_ADDR  in  ADDR_WIDTH  faulting fetch address, sampled with MISS
- MEM_REQ  out  1  burst request, held until MEM_ACK
- MEM_ADDR  out  ADDR_WIDTH  {latched addr[ADDR_WIDTH-1:2], 2'b00}; critical word address
- MEM_ACK  in  1  memory accepted request
- MEM_DATA_VALID  in  1  one beat of wrapping 16-beat burst
- MEM_DATA  in  DATA_WIDTH  beat data
- LINE_WR_EN  out  1  write one word into line store
- LINE_WR_WORD  out  4  word index for write
- LINE_WR_DATA  out  DATA_WIDTH  word data
- CRIT_WORD_VALID  out  1  one-cycle pulse, critical word available
- CRIT_WORD  out  DATA_WIDTH  critical word data
- TAG_WR_EN  out  1  one-cycle pulse, commit tag/valid
- REFILL_LINE_ADDR  out  ADDR_WIDTH-6  latched line address for tag write
- REFILL_BUSY  out  1  high from acceptance through DONE cycle inclusive
- REFILL_DONE  out  1  one-cycle pulse, coincident with TAG_WR_EN

## Operation
- States: IDLE, REQ, FILL, DONE.
- IDLE: on MISS=1, latch MISS_ADDR, set start = MISS_ADDR[5:2] and beat count = 0, then go to REQ.
- REQ: MEM_REQ=1. On MEM_ACK, go to FILL.
- FILL: each MEM_DATA_VALID beat is a write.
  - Write data = MEM_DATA.
  - Write index = (start + beat) mod 16; wraps through 15 → 0.
  - Beat 0 also pulses CRIT_WORD_VALID with CRIT_WORD = MEM_DATA.
  - Beat 15 moves the state to DONE.
- DONE: TAG_WR_EN=1 and REFILL_DONE=1 for one cycle, then IDLE.
- MISS outside IDLE is ignored; no queueing.
- MEM_DATA_VALID outside FILL is ignored, including in the same cycle as MEM_ACK.
- Beat counter is 5 bits internally so that exactly 16 beats are counted; index arithmetic is 4-bit modulo.
- Reset, including mid-burst: immediately IDLE.
  - All outputs 0: MEM_REQ, MEM_ADDR, LINE_WR_*, CRIT_*, TAG_WR_EN, REFILL_LINE_ADDR, REFILL_BUSY, REFILL_DONE.
  - Counter and latched address cleared.
  - Partial line is not tagged. Remaining memory beats after reset are ignored, because the state is IDLE.

## Timing
- All outputs are registered.
- Cycle N: MISS sampled in IDLE. From N+1, MEM_REQ and REFILL_BUSY are high.
- MEM_ACK sampled at cycle M: MEM_REQ low from M+1, FILL from M+1.
- Beat sampled at cycle k: LINE_WR_EN/WORD/DATA valid at k+1 for exactly one cycle. CRIT_WORD_VALID at k+1 for beat 0.
- Beats may have gaps; no write occurs on gap cycles.
- Last beat at cycle L: final LINE_WR_EN, TAG_WR_EN, REFILL_DONE and DONE state all at L+1. IDLE and REFILL_BUSY=0 at L+2. A new MISS can be sampled at L+2.
- Minimum miss-to-done latency (ACK at N+1, back-to-back beats N+2..N+17): REFILL_DONE at N+18.

## Structure
- Shared package icache_pkg holds:
  - state encoding: IDLE=2'd0, REQ=2'd1, FILL=2'd2, DONE=2'd3
  - WORDS_PER_LINE=16, WORD_SEL_WIDTH=4, WORD_OFFSET_LSB=2, LINE_OFFSET_LSB=6
- One natural sub-module, refill_beat_counter:
  - inputs: clear, load start, increment
  - outputs: wrapped 4-bit index, last-beat flag, first-beat flag

## Test plan
- Aligned miss: MISS_ADDR=0x0000_1000, ACK at once, 16 back-to-back beats D0..D15 → indices 0..15 in order with data D0..D15. CRIT_WORD=D0. REFILL_DONE at N+18. REFILL_LINE_ADDR=0x40.
- Wrap: MISS_ADDR=0x0000_1034 (offset 13) → MEM_ADDR=0x0000_1034. Indices 13,14,15,0,…,12. CRIT_WORD = beat 0 data. Exactly 16 LINE_WR_EN pulses.
- Stalled handshake: ACK delayed 5 cycles, beats with random 0–3 cycle gaps, MISS held high throughout → MEM_REQ held until ACK. No writes on gap cycles. Second MISS not accepted until 2 cycles after the last beat.
- Spurious valid: MEM_DATA_VALID in IDLE and in the same cycle as MEM_ACK → no LINE_WR_EN from those beats; the beat count still needs 16 FILL beats.
- Reset mid-burst: assert RST_N=0 after beat 7 → all outputs 0 immediately (asynchronously). No TAG_WR_EN. Later beats ignored. A fresh miss after release completes normally.

Source files
------------

// File: rtl/icache_refill_controller_pkg.sv
// Shared definitions for the instruction-cache line refill path.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_e;

  localparam int unsigned WORDS_PER_LINE  = 16;
  localparam int unsigned WORD_SEL_WIDTH  = 4;
  localparam int unsigned WORD_OFFSET_LSB = 2;
  localparam int unsigned LINE_OFFSET_LSB = 6;

  // Critical-word-first burst: the index walks from the start word and wraps mod 16.
  function automatic logic [WORD_SEL_WIDTH-1:0] wrap_index(
    input logic [WORD_SEL_WIDTH-1:0] start,
    input logic [WORD_SEL_WIDTH:0]   beat
  );
    return start + beat[WORD_SEL_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/icache_refill_controller_beat_counter.sv
// Beat counter for a wrapping 16-beat refill burst; yields the line-store word index.
module refill_beat_counter
  import icache_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      load,
  input  logic [WORD_SEL_WIDTH-1:0] start,
  input  logic                      inc,
  output logic [WORD_SEL_WIDTH-1:0] index,
  output logic                      last,
  output logic                      first
);

  logic [WORD_SEL_WIDTH:0]   beat_q, beat_d;
  logic [WORD_SEL_WIDTH-1:0] start_q, start_d;

  always_comb begin
    beat_d  = beat_q;
    start_d = start_q;
    if (clear) begin
      beat_d  = '0;
      start_d = '0;
    end else if (load) begin
      beat_d  = '0;
      start_d = start;
    end else if (inc) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      start_q <= '0;
    end else begin
      beat_q  <= beat_d;
      start_q <= start_d;
    end
  end

  assign index = wrap_index(start_q, beat_q);
  assign last  = (beat_q == (WORD_SEL_WIDTH + 1)'(WORDS_PER_LINE - 1));
  assign first = (beat_q == '0);

endmodule

// File: rtl/icache_refill_controller.sv
// I-cache line refill sequencer: one wrapping burst, critical word forwarded early, tag on completion.
module icache_refill_controller
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                MISS,
  input  logic [ADDR_WIDTH-1:0]               MISS_ADDR,
  output logic                                MEM_REQ,
  output logic [ADDR_WIDTH-1:0]               MEM_ADDR,
  input  logic                                MEM_ACK,
  input  logic                                MEM_DATA_VALID,
  input  logic [DATA_WIDTH-1:0]               MEM_DATA,
  output logic                                LINE_WR_EN,
  output logic [WORD_SEL_WIDTH-1:0]           LINE_WR_WORD,
  output logic [DATA_WIDTH-1:0]               LINE_WR_DATA,
  output logic                                CRIT_WORD_VALID,
  output logic [DATA_WIDTH-1:0]               CRIT_WORD,
  output logic                                TAG_WR_EN,
  output logic [ADDR_WIDTH-LINE_OFFSET_LSB-1:0] REFILL_LINE_ADDR,
  output logic                                REFILL_BUSY,
  output logic                                REFILL_DONE
);

  refill_state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:WORD_OFFSET_LSB] addr_q, addr_d;
  logic                                mem_req_q, mem_req_d;
  logic                                wr_en_q, wr_en_d;
  logic [WORD_SEL_WIDTH-1:0]           wr_word_q, wr_word_d;
  logic [DATA_WIDTH-1:0]               wr_data_q, wr_data_d;
  logic                                crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0]               crit_word_q, crit_word_d;
  logic                                done_q, done_d;
  logic                                busy_q, busy_d;

  logic                      accept, beat, cnt_clear;
  logic [WORD_SEL_WIDTH-1:0] beat_index;
  logic                      beat_last, beat_first;
  logic                      unused_byte_offset;

  assign unused_byte_offset = ^MISS_ADDR[WORD_OFFSET_LSB-1:0];

  assign accept    = (state_q == IDLE) && MISS;
  assign beat      = (state_q == FILL) && MEM_DATA_VALID;
  assign cnt_clear = (state_q == DONE);

  refill_beat_counter u_beat_counter (
    .clk   (CLK),
    .rst_n (RST_N),
    .clear (cnt_clear),
    .load  (accept),
    .start (MISS_ADDR[LINE_OFFSET_LSB-1:WORD_OFFSET_LSB]),
    .inc   (beat),
    .index (beat_index),
    .last  (beat_last),
    .first (beat_first)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_req_d    = mem_req_q;
    wr_en_d      = 1'b0;
    wr_word_d    = wr_word_q;
    wr_data_d    = wr_data_q;
    crit_valid_d = 1'b0;
    crit_word_d  = crit_word_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: if (MISS) begin
        state_d   = REQ;
        addr_d    = MISS_ADDR[ADDR_WIDTH-1:WORD_OFFSET_LSB];
        mem_req_d = 1'b1;
      end
      REQ: if (MEM_ACK) begin
        state_d   = FILL;
        mem_req_d = 1'b0;
      end
      FILL: if (MEM_DATA_VALID) begin
        wr_en_d   = 1'b1;
        wr_word_d = beat_index;
        wr_data_d = MEM_DATA;
        if (beat_first) begin
          crit_valid_d = 1'b1;
          crit_word_d  = MEM_DATA;
        end
        if (beat_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Busy covers every non-IDLE cycle, so it falls in step with the DONE->IDLE move.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      mem_req_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_word_q    <= '0;
      wr_data_q    <= '0;
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_req_q    <= mem_req_d;
      wr_en_q      <= wr_en_d;
      wr_word_q    <= wr_word_d;
      wr_data_q    <= wr_data_d;
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign MEM_REQ          = mem_req_q;
  assign MEM_ADDR         = {addr_q, {WORD_OFFSET_LSB{1'b0}}};
  assign LINE_WR_EN       = wr_en_q;
  assign LINE_WR_WORD     = wr_word_q;
  assign LINE_WR_DATA     = wr_data_q;
  assign CRIT_WORD_VALID  = crit_valid_q;
  assign CRIT_WORD        = crit_word_q;
  assign TAG_WR_EN        = done_q;
  assign REFILL_DONE      = done_q;
  assign REFILL_LINE_ADDR = addr_q[ADDR_WIDTH-1:LINE_OFFSET_LSB];
  assign REFILL_BUSY      = busy_q;

endmodule

// File: tb/tb_icache_refill_controller.sv
// Randomized bench for icache_refill_controller against a line-level write/tag model.
module tb_icache_refill_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        wr_en;
  logic [3:0]  wr_word;
  logic [31:0] wr_data;
  logic        crit_valid;
  logic [31:0] crit_word;
  logic        tag_en;
  logic [25:0] line_addr;
  logic        busy;
  logic        done;

  icache_refill_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK(clk), .RST_N(rst_n), .MISS(miss), .MISS_ADDR(miss_addr),
    .MEM_REQ(mem_req), .MEM_ADDR(mem_addr), .MEM_ACK(mem_ack),
    .MEM_DATA_VALID(mem_valid), .MEM_DATA(mem_data),
    .LINE_WR_EN(wr_en), .LINE_WR_WORD(wr_word), .LINE_WR_DATA(wr_data),
    .CRIT_WORD_VALID(crit_valid), .CRIT_WORD(crit_word), .TAG_WR_EN(tag_en),
    .REFILL_LINE_ADDR(line_addr), .REFILL_BUSY(busy), .REFILL_DONE(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, sampled on the falling edge.
  logic [3:0]  obs_word[$];
  logic [31:0] obs_data[$];
  int          crit_cnt, tag_cnt, done_cnt;
  logic [31:0] crit_seen;
  logic [25:0] tag_line;
  int unsigned done_cyc;

  always @(negedge clk) begin
    if (wr_en) begin
      obs_word.push_back(wr_word);
      obs_data.push_back(wr_data);
    end
    if (crit_valid) begin
      crit_cnt++;
      crit_seen = crit_word;
    end
    if (tag_en) begin
      tag_cnt++;
      tag_line = line_addr;
      done_cyc = cyc + 1;  // edge at which the pulse is sampled
    end
    if (done) done_cnt++;
  end

  // Stimulus-side bookkeeping
  logic [31:0] dat[16];
  int unsigned miss_cyc;
  int          req_bad;
  logic        req_after_ack;

  task automatic clear_mon();
    @(negedge clk);
    obs_word.delete();
    obs_data.delete();
    crit_cnt = 0; tag_cnt = 0; done_cnt = 0;
    crit_seen = '0; tag_line = '0; done_cyc = 0;
  endtask

  task automatic new_data();
    foreach (dat[i]) dat[i] = $urandom;
  endtask

  task automatic drive_refill(input logic [31:0] a, input int ack_dly, input int gap_max,
                              input bit hold_miss, input bit spur_ack, input int nbeats);
    int g;
    @(negedge clk);
    miss = 1'b1; miss_addr = a;
    @(negedge clk);
    miss_cyc = cyc;
    if (!hold_miss) miss = 1'b0;
    miss_addr = $urandom;
    req_bad = 0;
    for (int i = 0; i < ack_dly; i++) begin
      if (mem_req !== 1'b1) req_bad++;
      @(negedge clk);
    end
    if (mem_req !== 1'b1) req_bad++;
    mem_ack = 1'b1;
    if (spur_ack) begin mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF; end
    @(negedge clk);
    mem_ack = 1'b0; mem_valid = 1'b0;
    req_after_ack = mem_req;
    for (int b = 0; b < nbeats; b++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (g) @(negedge clk);
      mem_valid = 1'b1; mem_data = dat[b];
      @(negedge clk);
      mem_valid = 1'b0; mem_data = $urandom;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_req, mem_addr, wr_en, wr_word, wr_data, crit_valid, crit_word,
         tag_en, line_addr, busy, done} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_idle: busy=%b req=%b required 0 0", busy, mem_req);
    end
  endtask

  task automatic test_aligned();
    clear_mon(); new_data();
    drive_refill(32'h0000_1000, 0, 0, 1'b0, 1'b0, 16);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_word.size() != 16) begin
      errors++; $display("FAIL aligned_count: got %0d writes required 16", obs_word.size());
    end else
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_word[i] !== 4'(i) || obs_data[i] !== dat[i]) begin
          errors++;
          $display("FAIL aligned_write%0d: got %0d/%h required %0d/%h", i, obs_word[i], obs_data[i], i, dat[i]);
        end
      end
    checks++;
    if (crit_cnt != 1 || crit_seen !== dat[0]) begin
      errors++; $display("FAIL aligned_crit: got %0d pulses %h required 1 %h", crit_cnt, crit_seen, dat[0]);
    end
    checks++;
    if (done_cyc - miss_cyc != 18) begin
      errors++; $display("FAIL aligned_latency: got %0d required 18", done_cyc - miss_cyc);
    end
    checks++;
    if (tag_cnt != 1 || done_cnt != 1 || tag_line !== 26'h40) begin
      errors++; $display("FAIL aligned_tag: got tag=%0d done=%0d line=%h required 1 1 40", tag_cnt, done_cnt, tag_line);
    end
    checks++;
    if (mem_addr !== 32'h0000_1000 || req_bad != 0 || req_after_ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL aligned_req: got addr=%h reqbad=%0d reqack=%b busy=%b required 00001000 0 0 0", mem_addr, req_bad, req_after_ack, busy);
    end
  endtask

  task automatic test_wrap();
    clear_mon(); new_data();
    drive_refill(32'h0000_1034, 0, 0, 1'b0, 1'b0, 16);
    repeat (3) @(negedge clk);
    checks++;
    if (mem_addr !== 32'h0000_1034) begin
      errors++; $display("FAIL wrap_memaddr: got %h required 00001034", mem_addr);
    end
    checks++;
    if (obs_word.size() != 16) begin
      errors++; $display("FAIL wrap_count: got %0d writes required 16", obs_word.size());
    end else
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_word[i] !== 4'((13 + i) % 16) || obs_data[i] !== dat[i]) begin
          errors++;
          $display("FAIL wrap_write%0d: got %0d/%h required %0d/%h", i, obs_word[i], obs_data[i], (13 + i) % 16, dat[i]);
        end
      end
    checks++;
    if (crit_cnt != 1 || crit_seen !== dat[0] || tag_cnt != 1) begin
      errors++; $display("FAIL wrap_crit_tag: got crit=%0d %h tag=%0d required 1 %h 1", crit_cnt, crit_seen, tag_cnt, dat[0]);
    end
  endtask

  task automatic test_stalled();
    logic b_done, b_idle, r_idle, b_next, r_next;
    clear_mon(); new_data();
    drive_refill(32'h0000_2A48, 5, 3, 1'b1, 1'b0, 16);
    b_done = busy & done;
    @(negedge clk); b_idle = busy; r_idle = mem_req;
    @(negedge clk); b_next = busy; r_next = mem_req;
    checks++;
    if (req_bad != 0 || req_after_ack !== 1'b0) begin
      errors++; $display("FAIL stall_req_hold: got drops=%0d after_ack=%b required 0 0", req_bad, req_after_ack);
    end
    checks++;
    if (obs_word.size() != 16) begin
      errors++; $display("FAIL stall_count: got %0d writes required 16", obs_word.size());
    end else
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_word[i] !== 4'((4'h2 + i) % 16) || obs_data[i] !== dat[i]) begin
          errors++;
          $display("FAIL stall_write%0d: got %0d/%h required %0d/%h", i, obs_word[i], obs_data[i], (2 + i) % 16, dat[i]);
        end
      end
    checks++;
    if ({b_done, b_idle, r_idle, b_next, r_next} !== 5'b10011) begin
      errors++;
      $display("FAIL stall_rearm: got done/busy=%b idle busy/req=%b%b next busy/req=%b%b required 1 00 11", b_done, b_idle, r_idle, b_next, r_next);
    end
    checks++;
    if (tag_cnt != 1 || tag_line !== 26'(32'h0000_2A48 >> 6)) begin
      errors++; $display("FAIL stall_tag: got %0d line=%h required 1 %h", tag_cnt, tag_line, 32'h0000_2A48 >> 6);
    end
    miss = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_spurious();
    clear_mon(); new_data();
    mem_valid = 1'b1; mem_data = 32'hBAD0_0001;
    repeat (3) @(negedge clk);
    mem_valid = 1'b0;
    drive_refill(32'h0000_0F80, 1, 0, 1'b0, 1'b1, 15);
    repeat (3) @(negedge clk);
    checks++;
    if (tag_cnt != 0 || busy !== 1'b1 || obs_word.size() != 15) begin
      errors++; $display("FAIL spur_15beats: got tag=%0d busy=%b writes=%0d required 0 1 15", tag_cnt, busy, obs_word.size());
    end
    mem_valid = 1'b1; mem_data = dat[15];
    @(negedge clk); mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_word.size() != 16) begin
      errors++; $display("FAIL spur_count: got %0d writes required 16", obs_word.size());
    end else
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (obs_word[i] !== 4'(i) || obs_data[i] !== dat[i]) begin
          errors++;
          $display("FAIL spur_write%0d: got %0d/%h required %0d/%h", i, obs_word[i], obs_data[i], i, dat[i]);
        end
      end
    checks++;
    if (tag_cnt != 1 || crit_seen !== dat[0]) begin
      errors++; $display("FAIL spur_tag: got tag=%0d crit=%h required 1 %h", tag_cnt, crit_seen, dat[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    clear_mon(); new_data();
    drive_refill(32'h0000_5518, 0, 1, 1'b0, 1'b0, 8);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_addr, wr_en, wr_word, wr_data, crit_valid, crit_word,
         tag_en, line_addr, busy, done} !== '0) begin
      errors++; $display("FAIL midreset_async: got nonzero outputs, required all 0");
    end
    @(negedge clk); rst_n = 1'b1;
    for (int b = 8; b < 16; b++) begin
      mem_valid = 1'b1; mem_data = dat[b];
      @(negedge clk);
    end
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_word.size() != 8 || tag_cnt != 0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ignore: got writes=%0d tag=%0d busy=%b req=%b required 8 0 0 0", obs_word.size(), tag_cnt, busy, mem_req);
    end
    clear_mon(); new_data();
    a = $urandom;
    drive_refill(a, 0, 0, 1'b0, 1'b0, 16);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_word.size() != 16 || tag_cnt != 1 || tag_line !== a[31:6] || obs_word[0] !== a[5:2]) begin
      errors++; $display("FAIL midreset_fresh: got writes=%0d tag=%0d line=%h required 16 1 %h", obs_word.size(), tag_cnt, tag_line, a[31:6]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int t = 0; t < 4; t++) begin
      clear_mon(); new_data();
      a = $urandom;
      drive_refill(a, int'($urandom_range(3, 0)), 2, 1'b0, 1'b0, 16);
      repeat (3) @(negedge clk);
      checks++;
      if (obs_word.size() != 16) begin
        errors++; $display("FAIL rand%0d_count: got %0d writes required 16", t, obs_word.size());
      end else
        for (int i = 0; i < 16; i++) begin
          checks++;
          if (obs_word[i] !== 4'((int'(a[5:2]) + i) % 16) || obs_data[i] !== dat[i]) begin
            errors++;
            $display("FAIL rand%0d_write%0d: got %0d/%h required %0d/%h", t, i, obs_word[i], obs_data[i], (int'(a[5:2]) + i) % 16, dat[i]);
          end
        end
      checks++;
      if (mem_addr !== {a[31:2], 2'b00} || tag_line !== a[31:6] || crit_seen !== dat[0] || tag_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_meta: got addr=%h line=%h crit=%h tag=%0d required %h %h %h 1", t, mem_addr, tag_line, crit_seen, tag_cnt, {a[31:2], 2'b00}, a[31:6], dat[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_wrap();
    test_stalled();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
